// File: rtl/morse_text_pkg.sv
// Shared character codes, FSM states and row-select encoding for the
// Morse text buffer controller and its per-row storage.
package morse_text_pkg;

   localparam logic [7:0] SPACE    = 8'h20;
   localparam logic [7:0] BS       = 8'h08;
   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   typedef enum logic {SEL_TX, SEL_RX} sel_t;

   function automatic logic isPrintable(input logic [7:0] c);
      return (c >= PRINT_LO) && (c <= PRINT_HI);
   endfunction

endpackage

// File: rtl/text_row.sv
// One text row: working slots with a fill count, plus a display copy that is
// loaded from the working slots only on a snapshot request.
module text_row
   import morse_text_pkg::*;
#(
   parameter int LEN  = 5,
   parameter int CW   = 8,
   parameter int CNTW = $clog2(LEN + 1),
   parameter int IDXW = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wrEn,
   input  logic [CW-1:0]     i_char,
   input  logic              i_clrEn,
   input  logic [IDXW-1:0]   i_clrIdx,
   input  logic              i_clrLast,
   input  logic              i_snap,
   output logic [LEN*CW-1:0] o_disp,
   output logic [CNTW-1:0]   o_cnt
);

   localparam logic [CW-1:0]   CH_SPACE = CW'(SPACE);
   localparam logic [CW-1:0]   CH_BS    = CW'(BS);
   localparam logic [CNTW-1:0] FULL     = CNTW'(LEN);

   logic [CW-1:0]   r_slots [LEN];
   logic [CW-1:0]   r_disp  [LEN];
   logic [CNTW-1:0] r_cnt;

   // Snapshot takes the pre-update slot values, so a write landing on the
   // same edge only becomes visible at the following snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LEN; i++) begin
            r_slots[i] <= CH_SPACE;
            r_disp[i]  <= CH_SPACE;
         end
         r_cnt <= '0;
      end else begin
         if (i_snap) begin
            r_disp <= r_slots;
         end
         if (i_clrEn) begin
            r_slots[i_clrIdx] <= CH_SPACE;
            if (i_clrLast) begin
               r_cnt <= '0;
            end
         end else if (i_wrEn) begin
            if (i_char == CH_BS) begin
               if (r_cnt != '0) begin
                  r_slots[r_cnt - 1'b1] <= CH_SPACE;
                  r_cnt                 <= r_cnt - 1'b1;
               end
            end else if (isPrintable(8'(i_char))) begin
               if (r_cnt == FULL) begin
                  for (int i = 0; i < LEN - 1; i++) begin
                     r_slots[i] <= r_slots[i + 1];
                  end
                  r_slots[LEN - 1] <= i_char;
               end else begin
                  r_slots[r_cnt] <= i_char;
                  r_cnt          <= r_cnt + 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < LEN; g++) begin : g_pack
      assign o_disp[CW*g +: CW] = r_disp[g];
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/morse_text_buffer_ctrl.sv
// Arbitrates TX/RX character writes into two text rows, sequences row clears,
// and commits frame-stable display copies on the rising edge of vblank.
module morse_text_buffer_ctrl
   import morse_text_pkg::*;
#(
   parameter int LEN = 5,
   parameter int CW  = 8
) (
   input  logic                       iVGA_CLK,
   input  logic                       iRST,
   input  logic                       iTX_VALID,
   input  logic [CW-1:0]              iTX_CHAR,
   output logic                       oTX_READY,
   input  logic                       iRX_VALID,
   input  logic [CW-1:0]              iRX_CHAR,
   output logic                       oRX_READY,
   input  logic                       iCLEAR,
   input  logic                       iVBLANK,
   output logic [LEN*CW-1:0]          oTX_BUF,
   output logic [LEN*CW-1:0]          oRX_BUF,
   output logic [$clog2(LEN+1)-1:0]   oTX_CNT,
   output logic [$clog2(LEN+1)-1:0]   oRX_CNT,
   output logic                       oBUSY
);

   localparam int              CNTW     = $clog2(LEN + 1);
   localparam int              IDXW     = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);

   state_t          r_state;
   sel_t            r_lastGrant;
   sel_t            r_sel;
   logic [CW-1:0]   r_char;
   logic [IDXW-1:0] r_idx;
   logic            r_clearPend;
   logic            r_vbQ;

   logic w_clearReq;
   logic w_txReady;
   logic w_rxReady;
   logic w_snap;
   logic w_clrLast;

   assign w_clearReq = iCLEAR || r_clearPend;
   assign w_snap     = iVBLANK && !r_vbQ;
   assign w_clrLast  = (r_idx == LAST_IDX);

   // Round-robin: on contention the source not granted last time wins.
   always_comb begin
      w_txReady = 1'b0;
      w_rxReady = 1'b0;
      if ((r_state == IDLE) && !w_clearReq) begin
         w_txReady = iTX_VALID && (!iRX_VALID || (r_lastGrant == SEL_RX));
         w_rxReady = iRX_VALID && (!iTX_VALID || (r_lastGrant == SEL_TX));
      end
   end

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         r_state     <= IDLE;
         r_lastGrant <= SEL_RX;
         r_sel       <= SEL_TX;
         r_char      <= '0;
         r_idx       <= '0;
         r_clearPend <= 1'b0;
         r_vbQ       <= 1'b0;
      end else begin
         r_vbQ <= iVBLANK;
         case (r_state)
            IDLE: begin
               if (w_clearReq) begin
                  r_clearPend <= 1'b0;
                  r_idx       <= '0;
                  r_state     <= CLEAR;
               end else if (w_txReady) begin
                  r_char      <= iTX_CHAR;
                  r_sel       <= SEL_TX;
                  r_lastGrant <= SEL_TX;
                  r_state     <= WRITE;
               end else if (w_rxReady) begin
                  r_char      <= iRX_CHAR;
                  r_sel       <= SEL_RX;
                  r_lastGrant <= SEL_RX;
                  r_state     <= WRITE;
               end
            end
            WRITE: begin
               if (iCLEAR) begin
                  r_clearPend <= 1'b1;
               end
               r_state <= IDLE;
            end
            CLEAR: begin
               if (iCLEAR) begin
                  r_clearPend <= 1'b1;
               end
               if (w_clrLast) begin
                  r_state <= IDLE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   text_row #(.LEN(LEN), .CW(CW), .CNTW(CNTW), .IDXW(IDXW)) u_txRow (
      .clk       (iVGA_CLK),
      .rst       (iRST),
      .i_wrEn    ((r_state == WRITE) && (r_sel == SEL_TX)),
      .i_char    (r_char),
      .i_clrEn   (r_state == CLEAR),
      .i_clrIdx  (r_idx),
      .i_clrLast (w_clrLast),
      .i_snap    (w_snap),
      .o_disp    (oTX_BUF),
      .o_cnt     (oTX_CNT)
   );

   text_row #(.LEN(LEN), .CW(CW), .CNTW(CNTW), .IDXW(IDXW)) u_rxRow (
      .clk       (iVGA_CLK),
      .rst       (iRST),
      .i_wrEn    ((r_state == WRITE) && (r_sel == SEL_RX)),
      .i_char    (r_char),
      .i_clrEn   (r_state == CLEAR),
      .i_clrIdx  (r_idx),
      .i_clrLast (w_clrLast),
      .i_snap    (w_snap),
      .o_disp    (oRX_BUF),
      .o_cnt     (oRX_CNT)
   );

   assign oTX_READY = w_txReady;
   assign oRX_READY = w_rxReady;
   assign oBUSY     = (r_state != IDLE);

endmodule

// File: tb/tb_morse_text_buffer_ctrl.sv
// Directed plus randomized bench for morse_text_buffer_ctrl, checked every
// cycle against a transaction-level model of both text rows.
module tb_morse_text_buffer_ctrl;

   localparam int LEN = 5;
   localparam int CW  = 8;
   localparam logic [7:0] SP = 8'h20;

   logic             clk = 1'b0;
   logic             iRST = 1'b1;
   logic             iTX_VALID = 1'b0, iRX_VALID = 1'b0;
   logic [CW-1:0]    iTX_CHAR = '0, iRX_CHAR = '0;
   logic             iCLEAR = 1'b0, iVBLANK = 1'b0;
   logic             oTX_READY, oRX_READY, oBUSY;
   logic [LEN*CW-1:0] oTX_BUF, oRX_BUF;
   logic [2:0]       oTX_CNT, oRX_CNT;

   always #5 clk = ~clk;

   morse_text_buffer_ctrl #(.LEN(LEN), .CW(CW)) dut (
      .iVGA_CLK (clk),
      .iRST     (iRST),
      .iTX_VALID(iTX_VALID),
      .iTX_CHAR (iTX_CHAR),
      .oTX_READY(oTX_READY),
      .iRX_VALID(iRX_VALID),
      .iRX_CHAR (iRX_CHAR),
      .oRX_READY(oRX_READY),
      .iCLEAR   (iCLEAR),
      .iVBLANK  (iVBLANK),
      .oTX_BUF  (oTX_BUF),
      .oRX_BUF  (oRX_BUF),
      .oTX_CNT  (oTX_CNT),
      .oRX_CNT  (oRX_CNT),
      .oBUSY    (oBUSY)
   );

   // Reference model: rows as character arrays, the engine as "cycles of
   // work left" for the operation in flight.
   logic [7:0] mRow  [2][LEN];
   logic [7:0] mDisp [2][LEN];
   int         mCnt [2];
   int         mBusyLeft, mWrSel, mClrIdx, mLastGrant;
   bit         mOpClear, mClearPend, mVbPrev;
   logic [7:0] mWrChar;
   bit         expTxR, expRxR, sawTx, sawRx;
   int         errors = 0;
   int         checks = 0;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LEN*8-1:0] packModel(input int r, input bit disp);
      logic [LEN*8-1:0] v;
      for (int i = 0; i < LEN; i++) v[8*i +: 8] = disp ? mDisp[r][i] : mRow[r][i];
      return v;
   endfunction

   task automatic modelReset;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < LEN; i++) begin
            mRow[r][i]  = SP;
            mDisp[r][i] = SP;
         end
         mCnt[r] = 0;
      end
      mBusyLeft = 0; mClearPend = 0; mVbPrev = 0; mLastGrant = 1;
      mOpClear = 0; mClrIdx = 0; mWrSel = 0; mWrChar = 8'h00;
   endtask

   task automatic applyWrite(input int r, input logic [7:0] ch);
      if (ch == 8'h08) begin
         if (mCnt[r] > 0) begin
            mRow[r][mCnt[r]-1] = SP;
            mCnt[r]--;
         end
      end else if (ch >= 8'h20 && ch <= 8'h7E) begin
         if (mCnt[r] < LEN) begin
            mRow[r][mCnt[r]] = ch;
            mCnt[r]++;
         end else begin
            for (int i = 0; i < LEN - 1; i++) mRow[r][i] = mRow[r][i+1];
            mRow[r][LEN-1] = ch;
         end
      end
   endtask

   task automatic checkOutput;
      bit idleGo;
      idleGo = (mBusyLeft == 0) && !(iCLEAR || mClearPend);
      expTxR = idleGo && iTX_VALID && (!iRX_VALID || mLastGrant == 1);
      expRxR = idleGo && iRX_VALID && (!iTX_VALID || mLastGrant == 0);
      checkVal("txReady", 64'(oTX_READY), 64'(expTxR));
      checkVal("rxReady", 64'(oRX_READY), 64'(expRxR));
      checkVal("busy",    64'(oBUSY),     64'(mBusyLeft > 0));
      checkVal("txCnt",   64'(oTX_CNT),   64'(mCnt[0]));
      checkVal("rxCnt",   64'(oRX_CNT),   64'(mCnt[1]));
      checkVal("txBuf",   64'(oTX_BUF),   64'(packModel(0, 1)));
      checkVal("rxBuf",   64'(oRX_BUF),   64'(packModel(1, 1)));
   endtask

   task automatic modelEdge;
      if (iRST) begin
         modelReset();
         return;
      end
      if (iVBLANK && !mVbPrev) begin
         for (int r = 0; r < 2; r++)
            for (int i = 0; i < LEN; i++) mDisp[r][i] = mRow[r][i];
      end
      mVbPrev = iVBLANK;
      if (mBusyLeft > 0) begin
         if (iCLEAR) mClearPend = 1;
         if (mOpClear) begin
            mRow[0][mClrIdx] = SP;
            mRow[1][mClrIdx] = SP;
            mClrIdx++;
            if (mClrIdx == LEN) begin
               mCnt[0] = 0;
               mCnt[1] = 0;
            end
         end else begin
            applyWrite(mWrSel, mWrChar);
         end
         mBusyLeft--;
      end else if (iCLEAR || mClearPend) begin
         mClearPend = 0; mOpClear = 1; mClrIdx = 0; mBusyLeft = LEN;
      end else if (expTxR) begin
         mOpClear = 0; mWrSel = 0; mWrChar = iTX_CHAR; mLastGrant = 0; mBusyLeft = 1;
      end else if (expRxR) begin
         mOpClear = 0; mWrSel = 1; mWrChar = iRX_CHAR; mLastGrant = 1; mBusyLeft = 1;
      end
   endtask

   // One clock: inputs already driven, check after settling, advance model.
   task automatic applyStimulus;
      #1;
      checkOutput();
      sawTx = oTX_READY;
      sawRx = oRX_READY;
      modelEdge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sendChar(input int r, input logic [7:0] ch);
      bit got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (r == 0) begin iTX_VALID = 1; iTX_CHAR = ch; end
         else        begin iRX_VALID = 1; iRX_CHAR = ch; end
         applyStimulus();
         got = (r == 0) ? sawTx : sawRx;
      end
      iTX_VALID = 0;
      iRX_VALID = 0;
      checkVal("sendAccepted", 64'(got), 64'(1));
      applyStimulus();
   endtask

   task automatic vblankPulse;
      iVBLANK = 1;
      applyStimulus();
      iVBLANK = 0;
      applyStimulus();
   endtask

   initial begin
      logic [LEN*8-1:0] expRow;
      int               grantSeq [8];
      int               code;
      int               pick;
      logic [7:0]       ch;

      grantSeq = '{1, 0, 2, 0, 1, 0, 2, 0};
      iRST = 1;
      @(negedge clk);
      modelReset();
      iRST = 0;
      applyStimulus();

      // HELLO on TX, visible after a vblank rise
      sendChar(0, "H"); sendChar(0, "E"); sendChar(0, "L");
      sendChar(0, "L"); sendChar(0, "O");
      vblankPulse();
      expRow = "OLLEH";
      checkVal("helloDisp", 64'(oTX_BUF), 64'(expRow));
      checkVal("helloCnt",  64'(oTX_CNT), 64'(5));
      checkVal("rxBlank",   64'(oRX_BUF), 64'({LEN{8'h20}}));

      // Full row scrolls left
      sendChar(0, "W");
      vblankPulse();
      expRow = "WOLLE";
      checkVal("scrollDisp", 64'(oTX_BUF), 64'(expRow));
      checkVal("scrollCnt",  64'(oTX_CNT), 64'(5));

      // RX backspace handling, including backspace on an empty row
      sendChar(1, "W"); sendChar(1, "O");
      checkVal("bsCnt2", 64'(oRX_CNT), 64'(2));
      sendChar(1, 8'h08);
      checkVal("bsCnt1", 64'(oRX_CNT), 64'(1));
      sendChar(1, 8'h08);
      checkVal("bsCnt0", 64'(oRX_CNT), 64'(0));
      sendChar(1, 8'h08);
      checkVal("bsCntStay0", 64'(oRX_CNT), 64'(0));

      // Alternating grants after a fresh reset
      iRST = 1;
      applyStimulus();
      iRST = 0;
      iTX_VALID = 1; iTX_CHAR = "A";
      iRX_VALID = 1; iRX_CHAR = "B";
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         code = sawTx ? 1 : (sawRx ? 2 : 0);
         checkVal($sformatf("grant%0d", k), 64'(code), 64'(grantSeq[k]));
      end
      iTX_VALID = 0; iRX_VALID = 0;
      applyStimulus();

      // Clear requested while a write is in flight
      iTX_VALID = 1; iTX_CHAR = "Z";
      applyStimulus();
      checkVal("zAccepted", 64'(sawTx), 64'(1));
      iTX_VALID = 0; iCLEAR = 1;
      applyStimulus();
      iCLEAR = 0;
      applyStimulus();
      for (int k = 0; k < LEN; k++) begin
         #1;
         checkVal($sformatf("clrBusy%0d", k), 64'(oBUSY), 64'(1));
         applyStimulus();
      end
      applyStimulus();
      checkVal("clrTxCnt", 64'(oTX_CNT), 64'(0));
      checkVal("clrRxCnt", 64'(oRX_CNT), 64'(0));
      vblankPulse();
      checkVal("clrTxBuf", 64'(oTX_BUF), 64'({LEN{8'h20}}));
      checkVal("clrRxBuf", 64'(oRX_BUF), 64'({LEN{8'h20}}));

      // Display holds without vblank; commit coinciding with a write
      sendChar(0, "Q");
      checkVal("noVbHold", 64'(oTX_BUF), 64'({LEN{8'h20}}));
      iTX_VALID = 1; iTX_CHAR = "R";
      applyStimulus();
      iTX_VALID = 0; iVBLANK = 1;
      applyStimulus();
      expRow = "    Q";
      checkVal("preWriteDisp", 64'(oTX_BUF), 64'(expRow));
      iVBLANK = 0;
      applyStimulus();
      iVBLANK = 1;
      applyStimulus();
      expRow = "   RQ";
      checkVal("postWriteDisp", 64'(oTX_BUF), 64'(expRow));
      iVBLANK = 0;
      applyStimulus();

      // Randomized traffic against the model
      for (int k = 0; k < 800; k++) begin
         iTX_VALID = ($urandom_range(0, 1) == 1);
         iRX_VALID = ($urandom_range(0, 1) == 1);
         for (int s = 0; s < 2; s++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 5)      ch = 8'h41 + 8'($urandom_range(0, 25));
            else if (pick == 6) ch = 8'h08;
            else if (pick == 7) ch = 8'h20;
            else if (pick == 8) ch = 8'h7E;
            else                ch = 8'($urandom_range(0, 255));
            if (s == 0) iTX_CHAR = ch; else iRX_CHAR = ch;
         end
         iCLEAR  = ($urandom_range(0, 29) == 0);
         iRST    = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 5) == 0) iVBLANK = !iVBLANK;
         applyStimulus();
      end
      iTX_VALID = 0; iRX_VALID = 0; iCLEAR = 0; iRST = 0;
      applyStimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
